// File: rtl/brisc_pkg.sv
// brisc_pkg: shared widths, reset PC, NOP encoding, exception and fetch FSM enums
package brisc_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {XCPT_NONE, XCPT_INSTR_MISALIGNED} xcpt_e;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} fetch_state_e;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem port, redirect/stall handling, F->D outputs
module fetch_stage import brisc_pkg::*; #(
  parameter int XLEN = brisc_pkg::XLEN,
  parameter int ILEN = brisc_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic            imem_req_valid_out,
  input  logic            imem_req_ready_in,
  output logic [XLEN-1:0] imem_req_addr_out,
  input  logic            imem_rsp_valid_in,
  input  logic [ILEN-1:0] imem_rsp_data_in,
  output logic            valid_out,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output xcpt_e           xcpt_out
);
  localparam logic [ILEN-1:0] BUBBLE = ILEN'(NOP);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc4;
  logic [ILEN-1:0] buf_q, buf_d, instr;
  logic            req_valid, valid, misaligned;
  xcpt_e           xcpt;
  assign pc4 = pc_q + XLEN'(4);
  assign misaligned = pc_q[1:0] != 2'b00;
  // State, PC and hold buffer registers; reset drops any outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end
  // Next state and outputs; a redirect overrides stall and any in-flight response
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    req_valid = 1'b0;
    valid     = 1'b0;
    instr     = BUBBLE;
    xcpt      = XCPT_NONE;
    unique case (state_q)
      FETCH: begin
        valid     = misaligned;
        xcpt      = misaligned ? XCPT_INSTR_MISALIGNED : XCPT_NONE;
        req_valid = !misaligned && !redirect_valid_in;
        pc_d      = redirect_valid_in ? redirect_pc_in : pc_q;
        state_d   = req_valid && imem_req_ready_in ? WAIT : FETCH;
      end
      WAIT: begin
        valid   = imem_rsp_valid_in && !redirect_valid_in && !stall_in;
        instr   = valid ? imem_rsp_data_in : BUBBLE;
        buf_d   = imem_rsp_valid_in && stall_in && !redirect_valid_in ? imem_rsp_data_in : buf_q;
        pc_d    = redirect_valid_in ? redirect_pc_in : valid ? pc4 : pc_q;
        state_d = redirect_valid_in ? (imem_rsp_valid_in ? FETCH : DROP) :
                  !imem_rsp_valid_in ? WAIT : stall_in ? HOLD : FETCH;
      end
      HOLD: begin
        valid   = !redirect_valid_in;
        instr   = valid ? buf_q : BUBBLE;
        buf_d   = redirect_valid_in ? '0 : buf_q;
        pc_d    = redirect_valid_in ? redirect_pc_in : stall_in ? pc_q : pc4;
        state_d = redirect_valid_in || !stall_in ? FETCH : HOLD;
      end
      DROP: begin
        pc_d    = redirect_valid_in ? redirect_pc_in : pc_q;
        state_d = imem_rsp_valid_in ? FETCH : DROP;
      end
    endcase
  end
  assign imem_req_valid_out = req_valid && !reset;
  assign imem_req_addr_out  = reset ? RESET_PC : pc_q;
  assign valid_out          = valid && !reset;
  assign instr_out          = reset ? BUBBLE : instr;
  assign pc_out             = reset ? RESET_PC : pc_q;
  assign pc_plus4_out       = reset ? RESET_PC + XLEN'(4) : pc4;
  assign xcpt_out           = reset ? XCPT_NONE : xcpt;
endmodule
